// File: rtl/mips_16_trace_buf_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_16_trace_buf_if
// Purpose  : Drain-side handshake bundle between the trace buffer and its
//            debug consumer.
// Signals  : out_valid - a trace record is available at the head
//            out_ready - consumer accepts the head record this cycle
//            out_data  - head record {pc[15:0], alu[15:0]}
// Modports : master - trace buffer (drives valid/data, samples ready)
//            slave  - consumer     (drives ready, samples valid/data)
// Revision : 1.0 - initial release
// ============================================================================
interface mips_16_trace_buf_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/mips_16_trace_buf.sv
`default_nettype none
// ============================================================================
// Module   : mips_16_trace_buf
// Purpose  : Execution-trace capture FIFO downstream of the mips_16 core.
//            Records {pc, alu_result} each time the PC changes, queues the
//            records, and lets a debug consumer drain them via valid/ready.
//            Records that find no room are counted and flagged.
// Ports    : clk      - single clock, rising edge
//            reset    - asynchronous, active-low
//            pc_in    - core program counter
//            alu_in   - core ALU result
//            cap_en   - capture enable
//            clear    - synchronous flush (pointers, count, drop status)
//            out_if   - drain handshake (valid/ready/data), master side
//            count    - stored records, 0..DEPTH
//            overflow - sticky, a record was dropped
//            drop_cnt - saturating count of dropped records
// Revision : 1.0 - initial release
// ============================================================================
module mips_16_trace_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic [15:0]   pc_in,
  input  wire logic [15:0]   alu_in,
  input  wire logic          cap_en,
  input  wire logic          clear,
  mips_16_trace_buf_if.master out_if,
  output logic [AW:0]        count,
  output logic               overflow,
  output logic [7:0]         drop_cnt
);

  localparam logic [AW:0] C_FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] C_CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

  // Registered state
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          first_q,  first_d;
  logic [15:0]   last_pc_q, last_pc_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  // Event decode
  logic w_candidate;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // A record is only worth keeping when the PC moved; the very first sample
  // after reset/clear is always taken so the trace has a starting point.
  assign w_candidate = cap_en && (first_q || (pc_in != last_pc_q));
  assign w_full      = (count_q == C_FULL_CNT);
  assign w_pop       = (count_q != '0) && out_if.out_ready;
  // A full buffer still has room when the head leaves in the same cycle.
  assign w_push      = w_candidate && (!w_full || w_pop);
  assign w_drop      = w_candidate && !w_push;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    first_d    = first_q;
    last_pc_d  = last_pc_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (clear) begin
      // Flush wins over any same-cycle push/pop. Storage and last_pc are
      // left alone: first=1 guarantees the next sample is captured anyway.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      first_d    = 1'b1;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (w_candidate) begin
        first_d   = 1'b0;
        last_pc_d = pc_in;
      end

      if (w_push) begin
        mem_d[wr_ptr_q] = {pc_in, alu_in};
        wr_ptr_d        = wr_ptr_q + C_PTR_ONE;
      end

      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + C_PTR_ONE;
      end

      case ({w_push, w_pop})
        2'b10:   count_d = count_q + C_CNT_ONE;
        2'b01:   count_d = count_q - C_CNT_ONE;
        default: count_d = count_q;
      endcase

      if (w_drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      first_q    <= 1'b1;
      last_pc_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      first_q    <= first_d;
      last_pc_q  <= last_pc_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Head is read straight from storage: a pushed record becomes visible the
  // edge after it is written, with no same-cycle fall-through.
  assign out_if.out_valid = (count_q != '0);
  assign out_if.out_data  = mem_q[rd_ptr_q];
  assign count            = count_q;
  assign overflow         = overflow_q;
  assign drop_cnt         = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_16_trace_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_16_trace_buf
// Purpose  : Self-checking bench for mips_16_trace_buf. Expected records are
//            queued as stimulus is applied; a negedge monitor pops and
//            compares every record the DUT hands over.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_16_trace_buf;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic        clk;
  logic        reset;
  logic [15:0] pc_in;
  logic [15:0] alu_in;
  logic        cap_en;
  logic        clear;
  logic [AW:0] count;
  logic        overflow;
  logic [7:0]  drop_cnt;

  mips_16_trace_buf_if tr_if ();

  mips_16_trace_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .pc_in    (pc_in),
    .alu_in   (alu_in),
    .cap_en   (cap_en),
    .clear    (clear),
    .out_if   (tr_if.master),
    .count    (count),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drain monitor: a pop happens on the next rising edge whenever valid and
  // ready are both high (and no reset/clear suppresses it).
  always @(negedge clk) begin
    if (reset && !clear && tr_if.out_valid && tr_if.out_ready) begin
      if (sb_q.size() == 0) begin
        chk("stray_rec", {31'd0, tr_if.out_valid}, 32'd0);
      end else begin
        chk("drain", tr_if.out_data, sb_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b0;
    pc_in           = 16'h0000;
    alu_in          = 16'h0000;
    cap_en          = 1'b0;
    clear           = 1'b0;
    tr_if.out_ready = 1'b0;
    repeat (3) tick();

    // ---- reset state ----
    chk("rst_valid", {31'd0, tr_if.out_valid}, 32'd0);
    chk("rst_data", tr_if.out_data, 32'd0);
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_drop", {24'd0, drop_cnt}, 32'd0);

    // ---- first capture, repeated PC not re-captured ----
    cap_en = 1'b1;
    pc_in  = 16'h0000;
    alu_in = 16'h1234;
    reset  = 1'b1;
    sb_q.push_back(32'h0000_1234);
    repeat (3) tick();
    chk("first_count", {27'd0, count}, 32'd1);
    chk("first_valid", {31'd0, tr_if.out_valid}, 32'd1);
    chk("first_data", tr_if.out_data, 32'h0000_1234);
    cap_en          = 1'b0;
    tr_if.out_ready = 1'b1;
    tick();
    chk("first_drained", {27'd0, count}, 32'd0);

    // ---- stream in order with ready held high ----
    clear = 1'b1;
    tick();
    clear  = 1'b0;
    cap_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc_in  = 16'(2 * i);
      alu_in = 16'(2 * i + 1);
      sb_q.push_back({pc_in, alu_in});
      tick();
      chk("stream_cnt_le1", {31'd0, (count <= 5'd1)}, 32'd1);
    end
    cap_en = 1'b0;
    repeat (2) tick();
    chk("stream_empty", {27'd0, count}, 32'd0);
    chk("stream_sb_empty", sb_q.size(), 32'd0);

    // ---- fill and overflow ----
    clear = 1'b1;
    tick();
    clear           = 1'b0;
    tr_if.out_ready = 1'b0;
    cap_en          = 1'b1;
    for (int i = 0; i < 18; i++) begin
      pc_in  = 16'(16'h0100 + 2 * i);
      alu_in = 16'(i);
      if (i < DEPTH) sb_q.push_back({pc_in, alu_in});
      tick();
    end
    cap_en = 1'b0;
    tick();
    chk("fill_count", {27'd0, count}, 32'd16);
    chk("fill_ovf", {31'd0, overflow}, 32'd1);
    chk("fill_drop", {24'd0, drop_cnt}, 32'd2);

    // ---- full plus simultaneous push/pop ----
    pc_in           = 16'h0200;
    alu_in          = 16'hBEEF;
    cap_en          = 1'b1;
    tr_if.out_ready = 1'b1;
    sb_q.push_back(32'h0200_BEEF);
    tick();
    cap_en          = 1'b0;
    tr_if.out_ready = 1'b0;
    chk("full_pp_count", {27'd0, count}, 32'd16);
    chk("full_pp_drop", {24'd0, drop_cnt}, 32'd2);
    tr_if.out_ready = 1'b1;
    repeat (16) tick();
    chk("wrap_empty", {27'd0, count}, 32'd0);
    chk("wrap_sb_empty", sb_q.size(), 32'd0);

    // ---- clear priority (overflow still set from above) ----
    tr_if.out_ready = 1'b0;
    cap_en          = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pc_in  = 16'(16'h0300 + 2 * i);
      alu_in = 16'(16'hA0 + i);
      sb_q.push_back({pc_in, alu_in});
      tick();
    end
    chk("pre_clr_count", {27'd0, count}, 32'd5);
    chk("pre_clr_ovf", {31'd0, overflow}, 32'd1);
    clear           = 1'b1;
    pc_in           = 16'h030A;
    tr_if.out_ready = 1'b1;
    tick();
    clear           = 1'b0;
    tr_if.out_ready = 1'b0;
    sb_q.delete();
    chk("clr_count", {27'd0, count}, 32'd0);
    chk("clr_valid", {31'd0, tr_if.out_valid}, 32'd0);
    chk("clr_ovf", {31'd0, overflow}, 32'd0);
    chk("clr_drop", {24'd0, drop_cnt}, 32'd0);
    pc_in  = 16'h0308;
    alu_in = 16'h0055;
    sb_q.push_back(32'h0308_0055);
    tick();
    cap_en = 1'b0;
    tick();
    chk("post_clr_count", {27'd0, count}, 32'd1);
    chk("post_clr_data", tr_if.out_data, 32'h0308_0055);
    tr_if.out_ready = 1'b1;
    tick();
    chk("post_clr_drained", {27'd0, count}, 32'd0);

    // ---- asynchronous reset mid-drain ----
    tr_if.out_ready = 1'b0;
    cap_en          = 1'b1;
    for (int i = 0; i < 7; i++) begin
      pc_in  = 16'(16'h0400 + 2 * i);
      alu_in = 16'(16'hC0 + i);
      sb_q.push_back({pc_in, alu_in});
      tick();
    end
    cap_en = 1'b0;
    chk("pre_rst_count", {27'd0, count}, 32'd7);
    tr_if.out_ready = 1'b1;
    #2;
    reset = 1'b0;
    sb_q.delete();
    #1;
    chk("arst_valid", {31'd0, tr_if.out_valid}, 32'd0);
    chk("arst_data", tr_if.out_data, 32'd0);
    chk("arst_count", {27'd0, count}, 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (5) tick();
    chk("post_rst_valid", {31'd0, tr_if.out_valid}, 32'd0);
    chk("post_rst_count", {27'd0, count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_16_trace_buf.md
# mips_16_trace_buf

Execution-trace capture buffer placed directly downstream of the `mips_16` core. It samples the core's `pc_out` / `alu_result` pair whenever the program counter advances and queues each record in a FIFO. A debug consumer drains the records through a valid/ready handshake. Overflow is recorded, never silently lost.

## Interface
Parameters:
- `DEPTH`, 16, number of trace entries; power of two, minimum 2.
- `AW`, 4, pointer width; must equal log2(`DEPTH`).

Ports:
- `clk`, input, 1, single clock; all state updates on the rising edge.
- `reset`, input, 1, asynchronous, active-low; 0 forces every register to its reset value immediately.
- `pc_in`, input, 16, connected to `mips_16.pc_out`.
- `alu_in`, input, 16, connected to `mips_16.alu_result`.
- `cap_en`, input, 1, capture enable; 0 means no records are pushed.
- `clear`, input, 1, synchronous flush.
- `out_valid`, output, 1, a record is available at the head.
- `out_ready`, input, 1, consumer accepts the head record.
- `out_data`, output, 32, head record, `{pc[15:0], alu[15:0]}`.
- `count`, output, AW+1, number of stored records, 0..`DEPTH`.
- `overflow`, output, 1, sticky; a record was dropped.
- `drop_cnt`, output, 8, saturating count of dropped records.

## Operation
- **Sample qualify.** A candidate record exists in a cycle when `cap_en` is 1 and either `first` is set or `pc_in` differs from `last_pc`.
  - `first` is set at reset and by `clear`. It is cleared by the first qualified sample.
  - `last_pc` updates to `pc_in` on every qualified sample, whether the record is stored or dropped.
- **Push.**
  - A candidate is written at `wr_ptr` if the buffer is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the candidate is dropped: `overflow` is set to 1 and `drop_cnt` increments, saturating at 255.
- **Pop.** A pop occurs when `out_valid` and `out_ready` are both 1. It advances `rd_ptr`.
- **Simultaneous push and pop.** `count` is unchanged. This holds at full, at empty-with-pending-push, and mid-range.
- **Empty.** At empty with a push, the new record appears at the head on the following cycle. There is no fall-through in the same cycle.
- **Pointer wrap.** `rd_ptr` and `wr_ptr` are AW bits wide and wrap modulo `DEPTH`. Full and empty are derived from `count`, never from pointer equality alone.
- **Outputs.**
  - `out_valid` = (`count` != 0).
  - `out_data` = `mem[rd_ptr]`. It is undefined-free: it reads the stored value, and reads 0 after reset.
- **`clear`.** Highest priority after `reset`. In the clearing cycle it sets `count`, both pointers, `overflow` and `drop_cnt` to 0 and sets `first` to 1. Any push or pop in that cycle is ignored.
- **Reset values.**
  - `out_valid`=0, `out_data`=0, `count`=0, `overflow`=0, `drop_cnt`=0.
  - Storage entries are 0, `first`=1, `last_pc`=0.
- **Reset mid-operation.** Asserting reset mid-operation discards all contents without completing any in-flight pop.

## Timing
- Push latency: a record sampled at edge N is visible on `out_data` / `out_valid` after edge N, provided it is the head.
- Handshake:
  - `out_data` is stable while `out_valid`=1 and `out_ready`=0.
  - The consumer may hold `out_ready` high permanently, giving one record per cycle.
- `count`, `overflow` and `drop_cnt` reflect the edge's push/pop/drop outcome one edge after the event.
- Throughput: one push and one pop per cycle, sustained.
- `reset` is asynchronous on assertion. Deassertion is expected to be synchronized externally to `clk`.

## Test plan
- **Reset and first capture.** Hold reset low. Then release with `cap_en`=1 and `pc_in`=0x0000, `alu_in`=0x1234 stable for 3 cycles.
  - Exactly one record, `out_data`=0x00001234, with `count`=1.
  - The repeated PC is not re-captured.
- **Stream in order.** Step `pc_in` through 0,2,4,6 with `alu_in`=pc+1 and `out_ready`=1.
  - Records {0000_0001, 0002_0003, 0004_0005, 0006_0007} are delivered in order.
  - `count` never exceeds 1.
- **Fill and overflow.** Set `out_ready`=0 and push 18 distinct PCs with `DEPTH`=16.
  - `count`=16 and `overflow`=1, `drop_cnt`=2.
  - Draining then yields the first 16 records only.
- **Full plus simultaneous push/pop.** With the buffer full, apply one new PC and `out_ready`=1 in the same cycle.
  - The new record is accepted and `count` stays 16 with no drop.
  - After 16 pops the last record out is the new one, so `wr_ptr` wrap is correct.
- **Clear priority.** With `count`=5 and `overflow`=1, assert `clear` together with a push and a pop.
  - Next cycle `count`=0, `out_valid`=0, `overflow`=0, `drop_cnt`=0.
  - A following PC equal to the pre-clear `last_pc` is captured, because `first`=1.
- **Asynchronous reset mid-drain.** Pull `reset` low between clock edges while `count`=7.
  - All outputs go to 0 immediately.
  - After release, no stale records appear.
